edge_detect_multi: RTL and testbench

Parametrised successor to the single-channel rising edge detector. WIDTH independent channels, each with a runtime-selectable edge mode (off/rise/fall/both) and an optional input synchroniser. Produces per-channel one-cycle pulses, per-channel sticky flags with clear, an aggregate interrupt line and a saturating event counter. Sits between raw GPIO/status inputs and the interrupt/status register logic.

---
 rtl/edge_detect_multi.sv | 111 +++++++++++
 tb/tb_edge_detect_multi.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector with per-channel mode, optional input synchroniser,
// sticky flags, aggregate interrupt and saturating event counter.
module edge_detect_multi #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 0,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in,
  input  logic [2*WIDTH-1:0] mode,
  input  logic [WIDTH-1:0]   clr,
  input  logic               cnt_clr,
  output logic [WIDTH-1:0]   pulse,
  output logic [WIDTH-1:0]   sticky,
  output logic               irq,
  output logic [CNT_W-1:0]   evt_cnt
);

  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    prime_q, prime_d;
  logic             armed;
  logic [WIDTH-1:0] rise, fall, det;
  logic [CNT_W:0]   pop, base, sum;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = in;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];
      logic [WIDTH-1:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_d[i];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Pulses stay gated until prev holds real post-reset samples.
  assign armed = (prime_q == PRIME_DONE);

  always_comb begin
    prime_d = armed ? prime_q : prime_q + PW'(1);
    prev_d  = s;
    rise    = s & ~prev_q;
    fall    = ~s & prev_q;
    for (int i = 0; i < WIDTH; i++) begin
      det[i] = (mode[2*i] & rise[i]) | (mode[2*i+1] & fall[i]);
    end
    pulse_d  = armed ? det : '0;
    sticky_d = (sticky_q & ~clr) | pulse_d;
    irq_d    = |sticky_d;
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + {{CNT_W{1'b0}}, pulse_d[i]};
    end
    base  = cnt_clr ? '0 : {1'b0, cnt_q};
    sum   = base + pop;
    cnt_d = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_q  <= '0;
      prev_q   <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
      irq_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      prime_q  <= prime_d;
      prev_q   <= prev_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      irq_q    <= irq_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse   = pulse_q;
  assign sticky  = sticky_q;
  assign irq     = irq_q;
  assign evt_cnt = cnt_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: three instances (no sync, 2-stage sync,
// 4-bit counter) checked against a history-based model plus literals.
module tb_edge_detect_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  din = '0;
  logic [15:0] mode = 16'h5555;
  logic [7:0]  clr = '0;
  logic        cnt_clr = 1'b0;

  logic [7:0]  p0, s0, p2, s2, pc, sc;
  logic        i0, i2, ic;
  logic [15:0] c0, c2;
  logic [3:0]  cc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  edge_detect_multi #(.WIDTH(8), .SYNC_STAGES(0), .CNT_W(16)) d0 (
    .clk(clk), .rst_n(rst_n), .in(din), .mode(mode), .clr(clr),
    .cnt_clr(cnt_clr), .pulse(p0), .sticky(s0), .irq(i0), .evt_cnt(c0)
  );
  edge_detect_multi #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(16)) d2 (
    .clk(clk), .rst_n(rst_n), .in(din), .mode(mode), .clr(clr),
    .cnt_clr(cnt_clr), .pulse(p2), .sticky(s2), .irq(i2), .evt_cnt(c2)
  );
  edge_detect_multi #(.WIDTH(8), .SYNC_STAGES(0), .CNT_W(4)) dc (
    .clk(clk), .rst_n(rst_n), .in(din), .mode(mode), .clr(clr),
    .cnt_clr(cnt_clr), .pulse(pc), .sticky(sc), .irq(ic), .evt_cnt(cc)
  );

  logic [7:0]  g_pulse [3];
  logic [7:0]  g_sticky [3];
  logic        g_irq [3];
  logic [15:0] g_cnt [3];

  assign g_pulse[0] = p0;
  assign g_pulse[1] = p2;
  assign g_pulse[2] = pc;
  assign g_sticky[0] = s0;
  assign g_sticky[1] = s2;
  assign g_sticky[2] = sc;
  assign g_irq[0] = i0;
  assign g_irq[1] = i2;
  assign g_irq[2] = ic;
  assign g_cnt[0] = c0;
  assign g_cnt[1] = c2;
  assign g_cnt[2] = {12'b0, cc};

  // Model: input history sampled at each posedge since reset.
  logic [7:0]  past [1:3];
  int unsigned n_q;
  logic [7:0]  e_pulse [3];
  logic [7:0]  e_sticky [3];
  logic        e_irq [3];
  logic [15:0] e_cnt [3];

  function automatic int sk(int k);
    return (k == 1) ? 2 : 0;
  endfunction

  function automatic int cmax(int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  function automatic logic [7:0] lag(int l);
    case (l)
      0: return din;
      1: return past[1];
      2: return past[2];
      3: return past[3];
      default: return '0;
    endcase
  endfunction

  function automatic logic [7:0] edges(logic [7:0] nw, logic [7:0] od,
                                       logic [15:0] md);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      case (md[2*i +: 2])
        2'b00:   r[i] = 1'b0;
        2'b01:   r[i] = nw[i] && !od[i];
        2'b10:   r[i] = !nw[i] && od[i];
        default: r[i] = nw[i] != od[i];
      endcase
    end
    return r;
  endfunction

  // Posedge n (1-based) may pulse only once n >= S+2.
  function automatic logic [7:0] pk(int k);
    if (n_q < unsigned'(sk(k) + 1)) return '0;
    return edges(lag(sk(k)), lag(sk(k) + 1), mode);
  endfunction

  function automatic logic [15:0] sat(int k, int v);
    return (v > cmax(k)) ? 16'(cmax(k)) : 16'(v);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= 0;
      for (int k = 0; k < 3; k++) begin
        e_pulse[k]  <= '0;
        e_sticky[k] <= '0;
        e_irq[k]    <= 1'b0;
        e_cnt[k]    <= '0;
      end
    end else begin
      n_q <= (n_q < 7) ? n_q + 1 : n_q;
      past[1] <= din;
      past[2] <= past[1];
      past[3] <= past[2];
      for (int k = 0; k < 3; k++) begin
        e_pulse[k]  <= pk(k);
        e_sticky[k] <= (e_sticky[k] & ~clr) | pk(k);
        e_irq[k]    <= |((e_sticky[k] & ~clr) | pk(k));
        e_cnt[k]    <= sat(k, (cnt_clr ? 0 : int'(e_cnt[k]))
                              + $countones(pk(k)));
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("d%0d pulse", k), 16'(g_pulse[k]), 16'(e_pulse[k]));
        chk($sformatf("d%0d sticky", k), 16'(g_sticky[k]), 16'(e_sticky[k]));
        chk($sformatf("d%0d irq", k), 16'(g_irq[k]), 16'(e_irq[k]));
        chk($sformatf("d%0d cnt", k), g_cnt[k], e_cnt[k]);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int npulse;

  initial begin
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst pulse", 16'(p0), 16'h0);
    chk("rst sticky", 16'(s0), 16'h0);
    chk("rst irq", 16'(i0), 16'h0);
    chk("rst cnt", c0, 16'h0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Single rise on ch0, checked around the detecting edge
    din = 8'h01;
    #3 chk("t1 pre-edge pulse", 16'(p0), 16'h0);
    @(negedge clk);
    chk("t1 negedge pulse", 16'(p0), 16'h0);
    tick();
    chk("t1 pulse", 16'(p0), 16'h01);
    chk("t1 sticky", 16'(s0), 16'h01);
    chk("t1 irq", 16'(i0), 16'h1);
    chk("t1 cnt", c0, 16'd1);
    chk("t4 sync early", 16'(p2), 16'h0);
    tick();
    chk("t1 pulse drop", 16'(p0), 16'h0);
    chk("t4 sync early2", 16'(p2), 16'h0);
    tick();
    chk("t4 sync pulse", 16'(p2), 16'h01);

    // Sticky clear vs. simultaneous set
    din = 8'h00;
    tick();
    din = 8'h01;
    clr = 8'h01;
    tick();
    chk("t5 set-over-clr pulse", 16'(p0), 16'h01);
    chk("t5 set-over-clr sticky", 16'(s0), 16'h01);
    tick();
    chk("t5 clr sticky", 16'(s0), 16'h00);
    chk("t5 clr irq", 16'(i0), 16'h0);
    clr = 8'h00;
    repeat (3) tick();

    // Input held high through reset
    din = 8'hFF;
    tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t2 no pulse", 16'(p0), 16'h0);
    chk("t2 cnt0", c0, 16'd0);
    chk("t2 sync cnt0", c2, 16'd0);
    mode = 16'hAAAA;
    din = 8'h00;
    tick();
    chk("t2 fall all", 16'(p0), 16'hFF);
    chk("t2 cnt8", c0, 16'd8);
    chk("t2 cnt8 small", 16'(cc), 16'd8);
    tick();
    chk("t2 fall drop", 16'(p0), 16'h0);
    tick();
    chk("t2 sync fall all", 16'(p2), 16'hFF);

    // Saturation and counter clear
    mode = 16'hFFFF;
    din = 8'hFF;
    tick();
    chk("t6 cnt16", c0, 16'd16);
    chk("t6 sat", 16'(cc), 16'd15);
    din = 8'h00;
    tick();
    chk("t6 sat hold", 16'(cc), 16'd15);
    repeat (3) tick();
    din = 8'h07;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t6 clr cnt", c0, 16'd3);
    chk("t6 clr cnt small", 16'(cc), 16'd3);
    tick();
    din = 8'h00;
    tick();
    chk("t6 mid pulse", 16'(p0), 16'h07);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 rst pulse", 16'(p0), 16'h0);
    chk("t6 rst sticky", 16'(s0), 16'h0);
    chk("t6 rst irq", 16'(i0), 16'h0);
    chk("t6 rst cnt", c0, 16'h0);
    chk("t6 rst cnt small", 16'(cc), 16'h0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // Toggle ch3 every cycle, both-edge then rise-only
    mode = 16'h00C0;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      din[3] = ~din[3];
      tick();
      npulse += int'(p0[3]);
    end
    chk("t3 both pulses", 16'(npulse), 16'd10);
    chk("t3 both cnt", c0, 16'd10);
    tick();
    chk("t3 both end", 16'(p0), 16'h0);
    repeat (3) tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t3 cnt cleared", c0, 16'd0);
    mode = 16'h0040;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      din[3] = ~din[3];
      tick();
      npulse += int'(p0[3]);
    end
    chk("t3 rise pulses", 16'(npulse), 16'd5);
    chk("t3 rise cnt", c0, 16'd5);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
